// File: rtl/nios_mem_copy_master_if.sv
// rtl/nios_mem_copy_master_if.sv - Avalon-MM bus between the copy master and the on-chip RAM s1 slave
interface nios_mem_copy_master_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic              clken;
    logic [31:0]       readdata;

    modport master (
        output address,
        output byteenable,
        output chipselect,
        output write,
        output writedata,
        output clken,
        input  readdata
    );

    modport slave (
        input  address,
        input  byteenable,
        input  chipselect,
        input  write,
        input  writedata,
        input  clken,
        output readdata
    );
endinterface

// File: rtl/nios_mem_copy_master.sv
// rtl/nios_mem_copy_master.sv - single-port RAM word copier (optional MEMCPY_CHECKSUM_EN running sum)
module nios_mem_copy_master #(
    parameter int ADDR_W       = 10,
    parameter int LEN_W        = 11,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      src_addr,
    input  logic [ADDR_W-1:0]      dst_addr,
    input  logic [LEN_W-1:0]       length,
    output logic                   busy,
    output logic                   done,
`ifdef MEMCPY_CHECKSUM_EN
    output logic [31:0]            checksum,
`endif
    nios_mem_copy_master_if.master bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_LAT  = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    // Extra wait cycles between RD and CAP; only meaningful when READ_LATENCY > 1.
    localparam int              LAT_W    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 2);

    logic [2:0]        state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  remaining;
    logic [LAT_W-1:0]  lat_cnt;
    logic [31:0]       wdata;

    // Copy sequencer: one word per RD -> (LAT) -> CAP -> WR pass; done is registered out of FIN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            lat_cnt   <= '0;
            wdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= length;
                        busy      <= 1'b1;
                        state     <= (length == '0) ? S_FIN : S_RD;
                    end
                end
                S_RD: begin
                    lat_cnt <= '0;
                    state   <= (READ_LATENCY > 1) ? S_LAT : S_CAP;
                end
                S_LAT: begin
                    if (lat_cnt == LAT_LAST) begin
                        state <= S_CAP;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                S_CAP: begin
                    wdata   <= bus.readdata;
                    src_ptr <= src_ptr + ADDR_W'(1);
                    state   <= S_WR;
                end
                S_WR: begin
                    dst_ptr   <= dst_ptr + ADDR_W'(1);
                    remaining <= remaining - LEN_W'(1);
                    state     <= (remaining != LEN_W'(1)) ? S_RD : S_FIN;
                end
                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEMCPY_CHECKSUM_EN
    // Running sum of every captured word, cleared when a copy is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (state == S_IDLE && start) begin
            checksum <= '0;
        end else if (state == S_CAP) begin
            checksum <= checksum + bus.readdata;
        end
    end
`endif

    // Bus strobes decode straight from state so a reset idles the bus in the same cycle.
    assign bus.chipselect = (state == S_RD) || (state == S_WR);
    assign bus.write      = (state == S_WR);
    assign bus.address    = (state == S_RD) ? src_ptr :
                            (state == S_WR) ? dst_ptr : '0;
    assign bus.writedata  = wdata;
    assign bus.byteenable = 4'b1111;
    assign bus.clken      = 1'b1;

endmodule

// File: tb/tb_nios_mem_copy_master.sv
// tb/tb_nios_mem_copy_master.sv - scoreboard bench for nios_mem_copy_master with 1- and 2-cycle RAM models
`timescale 1ns/1ps
module tb_nios_mem_copy_master;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1;
    logic        reset_b = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [9:0]  src_a = '0, dst_a = '0, src_b = '0, dst_b = '0;
    logic [10:0] len_a = '0, len_b = '0;
    logic        busy_a, done_a, busy_b, done_b;
`ifdef MEMCPY_CHECKSUM_EN
    logic [31:0] checksum_a, checksum_b;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int cs_cnt_a = 0;

    int            q_done_a[$];
    int            q_done_b[$];
    logic [41:0]   q_wr_a[$];
    logic [41:0]   q_wr_b[$];

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic [9:0]  raddr_a, raddr_b;
    logic [31:0] rpipe_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nios_mem_copy_master_if #(.ADDR_W(10)) bus_a ();
    nios_mem_copy_master_if #(.ADDR_W(10)) bus_b ();

    nios_mem_copy_master #(.ADDR_W(10), .LEN_W(11), .READ_LATENCY(1)) dut_a (
        .clk      (clk),
        .reset    (reset_a),
        .start    (start_a),
        .src_addr (src_a),
        .dst_addr (dst_a),
        .length   (len_a),
        .busy     (busy_a),
        .done     (done_a),
`ifdef MEMCPY_CHECKSUM_EN
        .checksum (checksum_a),
`endif
        .bus      (bus_a.master)
    );

    nios_mem_copy_master #(.ADDR_W(10), .LEN_W(11), .READ_LATENCY(2)) dut_b (
        .clk      (clk),
        .reset    (reset_b),
        .start    (start_b),
        .src_addr (src_b),
        .dst_addr (dst_b),
        .length   (len_b),
        .busy     (busy_b),
        .done     (done_b),
`ifdef MEMCPY_CHECKSUM_EN
        .checksum (checksum_b),
`endif
        .bus      (bus_b.master)
    );

    // RAM A: registered address, unregistered output (1-cycle read latency)
    always @(posedge clk) begin
        if (bus_a.chipselect && bus_a.write) mem_a[bus_a.address] = bus_a.writedata;
        raddr_a <= bus_a.address;
    end
    assign bus_a.readdata = mem_a[raddr_a];

    // RAM B: extra output register (2-cycle read latency)
    always @(posedge clk) begin
        if (bus_b.chipselect && bus_b.write) mem_b[bus_b.address] = bus_b.writedata;
        raddr_b <= bus_b.address;
        rpipe_b <= mem_b[raddr_b];
    end
    assign bus_b.readdata = rpipe_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor A: pops expected writes and done cycles as the DUT presents them
    always @(negedge clk) begin
        logic [41:0] e;
        if (bus_a.chipselect) cs_cnt_a++;
        if (bus_a.chipselect && bus_a.write) begin
            if (q_wr_a.size() == 0) begin
                n_checks++;
                $display("FAIL wr_a unexpected: addr %0h data %0h, none expected", bus_a.address, bus_a.writedata);
            end else begin
                e = q_wr_a.pop_front();
                chk("wr_a addr", 64'(bus_a.address), 64'(e[41:32]));
                chk("wr_a data", 64'(bus_a.writedata), 64'(e[31:0]));
            end
        end
        if (done_a) begin
            if (q_done_a.size() == 0) begin
                n_checks++;
                $display("FAIL done_a unexpected at cycle %0d, none expected", cyc);
            end else begin
                chk("done_a cycle", 64'(cyc), 64'(q_done_a.pop_front()));
                chk("busy_a low at done", 64'(busy_a), 64'(0));
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        logic [41:0] e;
        if (bus_b.chipselect && bus_b.write) begin
            if (q_wr_b.size() == 0) begin
                n_checks++;
                $display("FAIL wr_b unexpected: addr %0h data %0h, none expected", bus_b.address, bus_b.writedata);
            end else begin
                e = q_wr_b.pop_front();
                chk("wr_b addr", 64'(bus_b.address), 64'(e[41:32]));
                chk("wr_b data", 64'(bus_b.writedata), 64'(e[31:0]));
            end
        end
        if (done_b) begin
            if (q_done_b.size() == 0) begin
                n_checks++;
                $display("FAIL done_b unexpected at cycle %0d, none expected", cyc);
            end else begin
                chk("done_b cycle", 64'(cyc), 64'(q_done_b.pop_front()));
            end
        end
    end

    // Issue a start on A and push the expected writes (first nwr words) and done cycle
    task automatic issue_a(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n,
                           input int nwr, input bit want_done, output int c0);
        logic [9:0] sa, da;
        @(negedge clk);
        src_a = s; dst_a = d; len_a = n; start_a = 1'b1;
        c0 = cyc;
        for (int i = 0; i < nwr; i++) begin
            sa = s + 10'(i);
            da = d + 10'(i);
            q_wr_a.push_back({da, mem_a[sa]});
        end
        if (want_done) q_done_a.push_back(c0 + 2 + 3 * int'(n));
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int max, input string nm);
        int k = 0;
        while (done_a !== 1'b1 && k < max) begin
            @(negedge clk);
            k++;
        end
        if (done_a !== 1'b1) begin
            n_checks++;
            $display("FAIL %s: no done within %0d cycles", nm, max);
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, cs0, k;
        logic [31:0] keep;

        for (int a = 0; a < 1024; a++) begin
            mem_a[a] = (a < 16) ? 32'(a * 3) : (32'hA000_0000 | 32'(a));
            mem_b[a] = (a < 16) ? 32'(a * 5 + 1) : (32'hB000_0000 | 32'(a));
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(busy_a), 64'(0));
        chk("rst done", 64'(done_a), 64'(0));
        chk("rst chipselect", 64'(bus_a.chipselect), 64'(0));
        chk("rst write", 64'(bus_a.write), 64'(0));
        chk("rst address", 64'(bus_a.address), 64'(0));
        chk("rst writedata", 64'(bus_a.writedata), 64'(0));
        chk("byteenable", 64'(bus_a.byteenable), 64'hF);
        chk("clken", 64'(bus_a.clken), 64'(1));
        reset_a = 1'b0;
        reset_b = 1'b0;
        @(negedge clk);

        // 16-word copy 0 -> 100
        cs0 = cs_cnt_a;
        issue_a(10'd0, 10'd100, 11'd16, 16, 1'b1, c0);
        chk("busy after start", 64'(busy_a), 64'(1));
        wait_done_a(80, "copy16");
        for (int i = 0; i < 16; i++) chk("copy16 ram", 64'(mem_a[100 + i]), 64'(i * 3));
        chk("copy16 chipselect cycles", 64'(cs_cnt_a - cs0), 64'(32));
`ifdef MEMCPY_CHECKSUM_EN
        chk("copy16 checksum", 64'(checksum_a), 64'd360);
`endif

        // Zero-length copy
        cs0  = cs_cnt_a;
        keep = mem_a[200];
        issue_a(10'd5, 10'd200, 11'd0, 0, 1'b1, c0);
        wait_done_a(10, "len0");
        chk("len0 chipselect cycles", 64'(cs_cnt_a - cs0), 64'(0));
        chk("len0 ram untouched", 64'(mem_a[200]), 64'(keep));

        // Source wrap 1022,1023,0,1 -> 500..503
        issue_a(10'd1022, 10'd500, 11'd4, 4, 1'b1, c0);
        wait_done_a(30, "wrap");
        chk("wrap ram 500", 64'(mem_a[500]), 64'hA000_03FE);
        chk("wrap ram 501", 64'(mem_a[501]), 64'hA000_03FF);
        chk("wrap ram 502", 64'(mem_a[502]), 64'(0));
        chk("wrap ram 503", 64'(mem_a[503]), 64'(3));

        // Start while busy is ignored
        keep = mem_a[600];
        issue_a(10'd20, 10'd300, 11'd8, 8, 1'b1, c0);
        while (cyc < c0 + 5) @(negedge clk);
        src_a = 10'd40; dst_a = 10'd600; len_a = 11'd3; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(40, "busy start");
        chk("busy start ram 307", 64'(mem_a[307]), 64'hA000_001B);
        chk("busy start 600 untouched", 64'(mem_a[600]), 64'(keep));

        // Reset at word 3 of 8
        keep = mem_a[703];
        issue_a(10'd0, 10'd700, 11'd8, 3, 1'b0, c0);
        while (cyc < c0 + 10) @(negedge clk);
        reset_a = 1'b1;
        #1;
        chk("abort chipselect", 64'(bus_a.chipselect), 64'(0));
        chk("abort address", 64'(bus_a.address), 64'(0));
        chk("abort busy", 64'(busy_a), 64'(0));
        repeat (2) @(negedge clk);
        reset_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort ram 700", 64'(mem_a[700]), 64'(0));
        chk("abort ram 702", 64'(mem_a[702]), 64'(6));
        chk("abort ram 703 untouched", 64'(mem_a[703]), 64'(keep));
        issue_a(10'd0, 10'd800, 11'd8, 8, 1'b1, c0);
        wait_done_a(40, "after abort");
        chk("after abort ram 807", 64'(mem_a[807]), 64'(21));

        // READ_LATENCY=2 instance, 4 words 2 -> 40
        @(negedge clk);
        src_b = 10'd2; dst_b = 10'd40; len_b = 11'd4; start_b = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 4; i++) q_wr_b.push_back({10'(40 + i), 32'((2 + i) * 5 + 1)});
        q_done_b.push_back(c0 + 18);
        @(negedge clk);
        start_b = 1'b0;
        k = 0;
        while (done_b !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (done_b !== 1'b1) begin
            n_checks++;
            $display("FAIL rl2: no done within 40 cycles");
        end
        @(negedge clk);
        chk("rl2 ram 40", 64'(mem_b[40]), 64'(11));
        chk("rl2 ram 43", 64'(mem_b[43]), 64'(26));
`ifdef MEMCPY_CHECKSUM_EN
        chk("rl2 checksum", 64'(checksum_b), 64'(74));
`endif

        repeat (3) @(negedge clk);
        chk("wr_a queue drained", 64'(q_wr_a.size()), 64'(0));
        chk("done_a queue drained", 64'(q_done_a.size()), 64'(0));
        chk("wr_b queue drained", 64'(q_wr_b.size()), 64'(0));
        chk("done_b queue drained", 64'(q_done_b.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
